// File: rtl/soc_bus_fabric_if.sv
// Bus bundle between the FemtoRV32 CPU, the soc_bus_fabric interconnect and its slaves.
// The fabric uses the master modport; the CPU/peripheral side uses slave.
interface soc_bus_fabric_if #(
  parameter int N_SLAVES = 8
);
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_wmask;
  logic                   mem_rstrb;
  logic [31:0]            mem_rdata;
  logic                   mem_rbusy;
  logic                   mem_wbusy;

  logic [N_SLAVES-1:0]    s_cs;
  logic                   s_rd;
  logic                   s_wr;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_wmask;
  logic [N_SLAVES*32-1:0] s_rdata;
  logic [N_SLAVES-1:0]    s_ready;

  logic                   err_pulse;
  logic [31:0]            err_addr;
  logic [7:0]             err_count;

  modport master (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, s_rdata, s_ready,
    output mem_rdata, mem_rbusy, mem_wbusy,
    output s_cs, s_rd, s_wr, s_addr, s_wdata, s_wmask,
    output err_pulse, err_addr, err_count
  );

  modport slave (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, s_rdata, s_ready,
    input  mem_rdata, mem_rbusy, mem_wbusy,
    input  s_cs, s_rd, s_wr, s_addr, s_wdata, s_wmask,
    input  err_pulse, err_addr, err_count
  );
endinterface

// File: rtl/soc_bus_fabric.sv
// Memory-mapped interconnect: decodes addr[31:16] to one-hot chip selects, stalls the CPU
// until the selected slave is ready or a timeout expires, and logs timed-out transfers.
module soc_bus_fabric #(
  parameter int                    N_SLAVES      = 8,
  parameter logic [N_SLAVES*16-1:0] SLAVE_MAP    = {16'h0046, 16'h0045, 16'h0044, 16'h0043,
                                                    16'h0042, 16'h0041, 16'h0040, 16'hFFFF},
  parameter int                    DEFAULT_SLAVE = 0,
  parameter int                    TIMEOUT       = 255,
  parameter logic [31:0]           ERR_RDATA     = 32'h66666666
) (
  input  logic             clk,
  input  logic             resetn,
  soc_bus_fabric_if.master bus
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_rdata;
  logic [N_SLAVES-1:0] r_cs;
  logic                r_rd;
  logic                r_wr;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wmask;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pend;
  logic [31:0]         r_pend_addr;
  logic                r_err_pulse;
  logic [31:0]         r_err_addr;
  logic [7:0]          r_err_count;

  logic                w_wr_req;
  logic [31:0]         w_dec_addr;
  logic [IDX_W-1:0]    w_dec_idx;
  logic                w_hit;
  logic [N_SLAVES-1:0] w_dec_cs;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;
  logic                w_acc_wr;
  logic                w_acc_rd;
  logic                w_done;
  logic                w_timeout;

  assign w_wr_req   = (bus.mem_wmask != 4'h0);
  // A pending read keeps the address captured alongside the write that deferred it.
  assign w_dec_addr = w_wr_req ? bus.mem_addr : (r_pend ? r_pend_addr : bus.mem_addr);

  always_comb begin
    w_dec_idx = IDX_W'(DEFAULT_SLAVE);
    w_hit     = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!w_hit && (w_dec_addr[31:16] == SLAVE_MAP[i*16 +: 16])) begin
        w_dec_idx = IDX_W'(i);
        w_hit     = 1'b1;
      end
    end
  end

  always_comb begin
    w_dec_cs    = '0;
    w_sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      w_dec_cs[i] = (w_dec_idx == IDX_W'(i));
      if (r_idx == IDX_W'(i)) w_sel_rdata = bus.s_rdata[i*32 +: 32];
    end
  end

  assign w_sel_ready = |(bus.s_ready & r_cs);

  always_comb begin
    w_next    = r_state;
    w_acc_wr  = 1'b0;
    w_acc_rd  = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          w_acc_wr = 1'b1;
          w_next   = WR_WAIT;
        end else if (bus.mem_rstrb || r_pend) begin
          w_acc_rd = 1'b1;
          w_next   = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (w_sel_ready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_rdata     <= '0;
      r_cs        <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_err_pulse <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_next;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_err_pulse <= 1'b0;

      if (w_acc_wr) begin
        r_addr  <= bus.mem_addr;
        r_wdata <= bus.mem_wdata;
        r_wmask <= bus.mem_wmask;
        r_idx   <= w_dec_idx;
        r_cs    <= w_dec_cs;
        r_wr    <= 1'b1;
        r_cnt   <= '0;
        if (bus.mem_rstrb) begin
          r_pend      <= 1'b1;
          r_pend_addr <= bus.mem_addr;
        end
      end else if (w_acc_rd) begin
        r_addr <= w_dec_addr;
        r_idx  <= w_dec_idx;
        r_cs   <= w_dec_cs;
        r_rd   <= 1'b1;
        r_cnt  <= '0;
        r_pend <= 1'b0;
      end else if (r_state == IDLE) begin
        r_cs <= '0;
      end

      if ((r_state != IDLE) && !w_done && !w_timeout) r_cnt <= r_cnt + 1'b1;

      if (w_done || w_timeout) begin
        r_cs    <= '0;
        r_wmask <= '0;
        if (r_state == RD_WAIT) r_rdata <= w_done ? w_sel_rdata : ERR_RDATA;
      end

      if (w_timeout) begin
        r_err_pulse <= 1'b1;
        r_err_addr  <= r_addr;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_rbusy = (r_state == RD_WAIT);
  assign bus.mem_wbusy = (r_state == WR_WAIT);
  assign bus.s_cs      = r_cs;
  assign bus.s_rd      = r_rd;
  assign bus.s_wr      = r_wr;
  assign bus.s_addr    = r_addr;
  assign bus.s_wdata   = r_wdata;
  assign bus.s_wmask   = r_wmask;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_addr  = r_err_addr;
  assign bus.err_count = r_err_count;

endmodule
